// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, WIDTH cycles per operation.
// Outputs are registered and update only when a result completes.

module serial_sub_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic br_i,
  output logic d_o,
  output logic br_o
);
  assign d_o  = a_i ^ b_i ^ br_i;
  assign br_o = (~a_i & b_i) | (~(a_i ^ b_i) & br_i);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, res_sh_q;
  logic [WIDTH-1:0] res_sh_d, d_msb;
  logic             br_q, bit_d, br_d;
  logic [CW-1:0]    cnt_q;
  logic             last_bit;
  logic             busy_q, done_q, borrow_q;
  logic [WIDTH-1:0] diff_q;

  serial_sub_cell u_cell (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .br_i (br_q),
    .d_o  (bit_d),
    .br_o (br_d)
  );

  // New bit enters at the MSB so the first processed bit ends up at bit 0.
  always_comb begin
    d_msb            = '0;
    d_msb[WIDTH-1]   = bit_d;
    res_sh_d         = (res_sh_q >> 1) | d_msb;
  end

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          br_q     <= br_d;
          res_sh_q <= res_sh_d;
          cnt_q    <= cnt_q + CW'(1);
          // Result becomes visible only here, never mid-shift.
          if (last_bit) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            diff_q   <= res_sh_d;
            borrow_q <= br_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at WIDTH=8 and WIDTH=1.

module tb_serial_subtractor;
  logic       clk, rst_n;
  logic       start8, busy8, done8, bo8;
  logic [7:0] a8, b8, diff8;
  logic       start1, busy1, done1, bo1;
  logic [0:0] a1, b1, diff1;

  int total = 0;
  int bad   = 0;
  logic [7:0] prev8 = '0;
  logic       prevb = 1'b0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] ed, input logic eb, input string tag);
    int cyc, nbusy;
    @(negedge clk); a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0; a8 = ~a; b8 = 8'h00;
    chk({tag, "_hold_diff"}, diff8, prev8);
    chk({tag, "_hold_bo"}, bo8, prevb);
    cyc = 1; nbusy = 0;
    while (!done8 && cyc < 40) begin
      if (busy8) nbusy++;
      @(negedge clk); cyc++;
    end
    chk({tag, "_latency"}, cyc - 1, 8);
    chk({tag, "_busycnt"}, nbusy, 8);
    chk({tag, "_busy_at_done"}, busy8, 1'b0);
    chk({tag, "_diff"}, diff8, ed);
    chk({tag, "_borrow"}, bo8, eb);
    prev8 = ed; prevb = eb;
    @(negedge clk);
    chk({tag, "_pulse"}, done8, 1'b0);
  endtask

  task automatic op1(input logic a, input logic b, input logic [1:0] e, input string tag);
    int cyc;
    @(negedge clk); a1 = a; b1 = b; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0; a1 = ~a; b1 = ~b;
    chk({tag, "_busy"}, busy1, 1'b1);
    cyc = 1;
    while (!done1 && cyc < 10) begin
      @(negedge clk); cyc++;
    end
    chk({tag, "_latency"}, cyc - 1, 1);
    chk({tag, "_result"}, {bo1, diff1}, e);
  endtask

  initial begin
    logic [8:0] e9;
    logic [7:0] ra, rb;
    logic       sa, sb;
    int tprev, nbusy, npulse, nd;
    logic [7:0] got;

    // Reset with start asserted: reset must win.
    rst_n = 1'b0; start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_diff", diff8, 8'h00);
    chk("rst_borrow", bo8, 1'b0);
    chk("rst_busy1", busy1, 1'b0);
    chk("rst_diff1", {bo1, diff1}, 2'b00);
    start8 = 1'b0; start1 = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy8, 1'b0);

    op8(8'h05, 8'h03, 8'h02, 1'b0, "s05_03");
    op8(8'h03, 8'h05, 8'hFE, 1'b1, "s03_05");
    op8(8'h00, 8'h01, 8'hFF, 1'b1, "s00_01");
    op8(8'hFF, 8'hFF, 8'h00, 1'b0, "sFF_FF");

    // Second start in RUN must be ignored.
    @(negedge clk); a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'h80; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    nd = 0; got = '0;
    for (int i = 0; i < 15; i++) begin
      if (done8) begin nd++; got = diff8; end
      @(negedge clk);
    end
    chk("ignore_ndone", nd, 1);
    chk("ignore_diff", got, 8'h0F);
    chk("ignore_busy", busy8, 1'b0);
    prev8 = 8'h0F; prevb = 1'b0;

    // Start held high: back-to-back operations.
    @(negedge clk); a8 = 8'h0A; b8 = 8'h02; start8 = 1'b1;
    tprev = -1; nbusy = 0; npulse = 0;
    for (int t = 0; t < 40 && npulse < 3; t++) begin
      @(negedge clk);
      if (done8) begin
        chk("b2b_diff", diff8, 8'h08);
        chk("b2b_nobusy", busy8, 1'b0);
        if (tprev >= 0) begin
          chk("b2b_period", t - tprev, 9);
          chk("b2b_busycnt", nbusy, 8);
        end
        tprev = t; nbusy = 0; npulse++;
      end else if (busy8) begin
        nbusy++;
      end
    end
    start8 = 1'b0;
    chk("b2b_npulse", npulse, 3);
    @(negedge clk);
    prev8 = 8'h08; prevb = 1'b0;

    // Reset mid-RUN aborts with no done and clears the result.
    @(negedge clk); a8 = 8'h55; b8 = 8'h11; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy8, 1'b0);
    chk("abort_done", done8, 1'b0);
    chk("abort_diff", diff8, 8'h00);
    chk("abort_borrow", bo8, 1'b0);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 || busy8) nd++;
    end
    chk("abort_quiet", nd, 0);
    prev8 = 8'h00; prevb = 1'b0;
    op8(8'h09, 8'h04, 8'h05, 1'b0, "after_abort");

    op1(1'b0, 1'b1, 2'b11, "w1_0_1");
    op1(1'b1, 1'b1, 2'b00, "w1_1_1");
    op1(1'b1, 1'b0, 2'b01, "w1_1_0");

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      e9 = {1'b0, ra} - {1'b0, rb};
      op8(ra, rb, e9[7:0], e9[8], "rand8");
    end
    for (int i = 0; i < 1000; i++) begin
      sa = 1'($urandom); sb = 1'($urandom);
      op1(sa, sb, {1'b0, sa} - {1'b0, sb}, "rand1");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand and result width in bits (legal range 1..32).
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request to begin a subtraction; sampled on the rising edge.
REQ-005 a  input  WIDTH  minuend, unsigned; sampled only on the edge that accepts start.
REQ-006 b  input  WIDTH  subtrahend, unsigned; sampled only on the edge that accepts start.
REQ-007 busy  output  1  high while a subtraction is in progress.
REQ-008 done  output  1  one-cycle pulse marking a valid result.
REQ-009 diff  output  WIDTH  result a - b modulo 2^WIDTH.
REQ-010 borrow_out  output  1  final borrow: 1 iff a < b (unsigned).

Function
REQ-011 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-012 IDLE -> RUN SHALL occur on a rising edge with start=1; on that edge the block SHALL capture a and b into shift registers, clear the borrow flop, and clear the bit counter.
REQ-013 In RUN, each edge SHALL process one bit, LSB first, as d = a0 ^ b0 ^ br and br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-014 In RUN, each edge SHALL shift d into the result register MSB-end so that after WIDTH shifts diff[0] holds the first bit processed.
REQ-015 RUN SHALL last exactly WIDTH cycles; on the WIDTH-th RUN edge the FSM SHALL go to DONE, diff SHALL hold the full result, and borrow_out SHALL hold br_next.
REQ-016 Latency SHALL be WIDTH cycles from the start-accepting edge to the first cycle with done=1.
REQ-017 done SHALL be 1 only in DONE, and DONE SHALL last exactly one cycle.
REQ-018 DONE -> RUN SHALL occur if start=1 on that edge, with the same capture as REQ-012; otherwise DONE -> IDLE.
REQ-019 busy SHALL be 1 in RUN only; busy and done SHALL never be high together.
REQ-020 start while in RUN SHALL be ignored: no recapture, no restart, and the result SHALL be unaffected.
REQ-021 Changes on a and b outside the accepting edge SHALL NOT affect the result in progress.
REQ-022 diff and borrow_out SHALL hold their last result through IDLE, and through RUN, until the next DONE. The result register SHALL NOT be visible mid-shift: it is a separate shift register copied to diff on entry to DONE.
REQ-023 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within an operation.
REQ-024 WIDTH=1 SHALL be supported, with one RUN cycle.
REQ-025 The design SHALL contain no combinational path from any input to any output.

Reset
REQ-026 With rst_n=0 on a rising edge, the FSM SHALL enter IDLE and busy, done, diff, borrow_out, the borrow flop, the counter and the shift registers SHALL all clear to 0.
REQ-027 Reset SHALL take priority over start, including start in the same cycle.
REQ-028 Reset in RUN SHALL abort the operation with no done pulse, and no stale result SHALL appear afterwards.
REQ-029 After rst_n returns high, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-030 WIDTH=8, a=8'h05, b=8'h03, start for one cycle -> busy for 8 cycles, then done=1 for one cycle with diff=8'h02, borrow_out=0.
REQ-031 a=8'h03, b=8'h05 -> diff=8'hFE, borrow_out=1; a=8'h00, b=8'h01 -> diff=8'hFF, borrow_out=1; a=8'hFF, b=8'hFF -> diff=8'h00, borrow_out=0.
REQ-032 start asserted again at RUN cycle 3 with a=8'h80, b=8'h01, after first start with a=8'h10, b=8'h01 -> single done with diff=8'h0F; second request ignored.
REQ-033 start held high continuously with a=8'h0A, b=8'h02 -> back-to-back results diff=8'h08 every 9 cycles, with done pulses separated by 8 busy cycles.
REQ-034 rst_n=0 at RUN cycle 4 -> busy=0 and diff=0 next cycle, no done pulse; a fresh start with a=8'h09, b=8'h04 then yields diff=8'h05 after 8 cycles.
REQ-035 Random test: 1000 random a/b pairs at WIDTH=8 and WIDTH=1 -> {borrow_out, diff} SHALL equal the (WIDTH+1)-bit value of a - b in every case.
